// File: rtl/subtrator_serial_8bits.sv
// ============================================================================
// Module      : subtrator_serial_8bits
// Description : Bit-serial W-bit subtractor D = A - B - Bin, LSB first, one
//               full-subtractor cell, start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtrator_serial_8bits #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bin,
  output logic [W-1:0] D,
  output logic         Bout,
  output logic         V,
  output logic         busy,
  output logic         done
);

  localparam int c_cnt_w = (W > 1) ? $clog2(W) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(W - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_ra;
  logic [W-1:0]       r_rb;
  logic [W-1:0]       r_rd;
  logic               r_bw;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_a_msb;
  logic               r_b_msb;

  logic               w_d;
  logic               w_bw;
  logic [W-1:0]       w_rd_next;

  // Full-subtractor cell on the operand LSBs
  assign w_d       = r_ra[0] ^ r_rb[0] ^ r_bw;
  assign w_bw      = (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_bw);
  assign w_rd_next = {w_d, r_rd[W-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == c_cnt_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra    <= '0;
      r_rb    <= '0;
      r_rd    <= '0;
      r_bw    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      D       <= '0;
      Bout    <= 1'b0;
      V       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ra    <= A;
            r_rb    <= B;
            r_bw    <= Bin;
            r_cnt   <= '0;
            r_a_msb <= A[W-1];
            r_b_msb <= B[W-1];
          end
        end
        S_RUN: begin
          r_ra  <= r_ra >> 1;
          r_rb  <= r_rb >> 1;
          r_rd  <= w_rd_next;
          r_bw  <= w_bw;
          r_cnt <= r_cnt + c_cnt_one;
          // The last cell's d bit is the result MSB used for overflow
          if (r_cnt == c_cnt_last) begin
            D    <= w_rd_next;
            Bout <= w_bw;
            V    <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
